// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: one-hot INTERVAL/START/DATA/PARITY/STOP walk paced by the baud pulse.
// Define UART_TX_TWO_STOPBIT_EN to hold STOPBIT for two baud periods.
module uart_tx_fsm #(
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_BaudSig_i,
    input  logic       p_FifoEmpty_i,
    input  logic       p_ParityEn_i,
    output logic [4:0] State_o,
    output logic [3:0] BitCounter_o,
    output logic       p_ParityCalTrigger_o,
    output logic       p_TxBusy_o,
    output logic       p_FrameDone_o
);

    typedef enum logic [4:0] {
        INTERVAL  = 5'b0_0001,
        STARTBIT  = 5'b0_0010,
        DATABITS  = 5'b0_0100,
        PARITYBIT = 5'b0_1000,
        STOPBIT   = 5'b1_0000
    } state_t;

    localparam logic [3:0] GAP_MAX = 4'(IDLE_GAP);

    state_t     stateR, stateNext;
    logic [3:0] bitCntR, bitCntNext;
    logic [3:0] gapCntR, gapCntNext;
    logic       parity_en_r, parityEnNext;
    logic       trigR, trigNext;
    logic       doneR, doneNext;
    logic       busyR, busyNext;
    logic       gapReached;
`ifdef UART_TX_TWO_STOPBIT_EN
    logic       stopCntR, stopCntNext;
`endif

    // Start is allowed when this baud pulse completes the required idle gap.
    assign gapReached = ({1'b0, gapCntR} + 5'd1) >= {1'b0, GAP_MAX};

    always_comb begin
        stateNext    = stateR;
        bitCntNext   = bitCntR;
        gapCntNext   = gapCntR;
        parityEnNext = parity_en_r;
        trigNext     = 1'b0;
        doneNext     = 1'b0;
`ifdef UART_TX_TWO_STOPBIT_EN
        stopCntNext  = stopCntR;
`endif
        case (stateR)
            INTERVAL: begin
                if (p_BaudSig_i) begin
                    if (gapReached && !p_FifoEmpty_i) begin
                        stateNext    = STARTBIT;
                        gapCntNext   = 4'd0;
                        parityEnNext = p_ParityEn_i;
                    end else if (gapCntR < GAP_MAX) begin
                        gapCntNext = gapCntR + 4'd1;
                    end
                end
            end
            STARTBIT: begin
                if (p_BaudSig_i) begin
                    stateNext  = DATABITS;
                    bitCntNext = 4'd0;
                end
            end
            DATABITS: begin
                if (p_BaudSig_i) begin
                    if (bitCntR == 4'd7) begin
                        bitCntNext = 4'd0;
                        trigNext   = 1'b1;
                        stateNext  = parity_en_r ? PARITYBIT : STOPBIT;
`ifdef UART_TX_TWO_STOPBIT_EN
                        stopCntNext = 1'b0;
`endif
                    end else begin
                        bitCntNext = bitCntR + 4'd1;
                    end
                end
            end
            PARITYBIT: begin
                if (p_BaudSig_i) begin
                    stateNext = STOPBIT;
`ifdef UART_TX_TWO_STOPBIT_EN
                    stopCntNext = 1'b0;
`endif
                end
            end
            STOPBIT: begin
                if (p_BaudSig_i) begin
`ifdef UART_TX_TWO_STOPBIT_EN
                    if (!stopCntR) begin
                        stopCntNext = 1'b1;
                    end else begin
                        stateNext   = INTERVAL;
                        doneNext    = 1'b1;
                        gapCntNext  = 4'd0;
                        stopCntNext = 1'b0;
                    end
`else
                    stateNext  = INTERVAL;
                    doneNext   = 1'b1;
                    gapCntNext = 4'd0;
`endif
                end
            end
            default: begin
                // Non-one-hot state: recover to a clean idle without pulses.
                stateNext  = INTERVAL;
                bitCntNext = 4'd0;
                gapCntNext = 4'd0;
`ifdef UART_TX_TWO_STOPBIT_EN
                stopCntNext = 1'b0;
`endif
            end
        endcase
        busyNext = (stateNext != INTERVAL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateR      <= INTERVAL;
            bitCntR     <= 4'd0;
            gapCntR     <= 4'd0;
            parity_en_r <= 1'b0;
            trigR       <= 1'b0;
            doneR       <= 1'b0;
            busyR       <= 1'b0;
`ifdef UART_TX_TWO_STOPBIT_EN
            stopCntR    <= 1'b0;
`endif
        end else begin
            stateR      <= stateNext;
            bitCntR     <= bitCntNext;
            gapCntR     <= gapCntNext;
            parity_en_r <= parityEnNext;
            trigR       <= trigNext;
            doneR       <= doneNext;
            busyR       <= busyNext;
`ifdef UART_TX_TWO_STOPBIT_EN
            stopCntR    <= stopCntNext;
`endif
        end
    end

    assign State_o              = stateR;
    assign BitCounter_o         = bitCntR;
    assign p_ParityCalTrigger_o = trigR;
    assign p_TxBusy_o           = busyR;
    assign p_FrameDone_o        = doneR;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: directed scenarios plus random baud/FIFO/parity traffic
// checked against a frame-list reference model.
module tb_uart_tx_fsm;
    localparam int GAP = 3;
`ifdef UART_TX_TWO_STOPBIT_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif
    localparam logic [4:0] S_INT   = 5'b0_0001;
    localparam logic [4:0] S_START = 5'b0_0010;
    localparam logic [4:0] S_DATA  = 5'b0_0100;
    localparam logic [4:0] S_PAR   = 5'b0_1000;
    localparam logic [4:0] S_STOP  = 5'b1_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p_BaudSig_i = 1'b0;
    logic       p_FifoEmpty_i = 1'b1;
    logic       p_ParityEn_i = 1'b0;
    logic [4:0] State_o;
    logic [3:0] BitCounter_o;
    logic       p_ParityCalTrigger_o;
    logic       p_TxBusy_o;
    logic       p_FrameDone_o;

    uart_tx_fsm #(.IDLE_GAP(GAP)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .p_BaudSig_i          (p_BaudSig_i),
        .p_FifoEmpty_i        (p_FifoEmpty_i),
        .p_ParityEn_i         (p_ParityEn_i),
        .State_o              (State_o),
        .BitCounter_o         (BitCounter_o),
        .p_ParityCalTrigger_o (p_ParityCalTrigger_o),
        .p_TxBusy_o           (p_TxBusy_o),
        .p_FrameDone_o        (p_FrameDone_o)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    // Reference model: a frame is a list of per-baud-period slots, consumed one per baud.
    typedef struct packed {
        logic [4:0] st;
        logic [3:0] bc;
    } slot_t;
    slot_t frame_q[$];
    bit    inFrame = 1'b0;
    int    idleBauds = 0;
    bit    expTrig = 1'b0;
    bit    expDone = 1'b0;
    bit    latchedPar = 1'b0;
    int    startCycle = 0;
    bit    fixed16 = 1'b0;
    bit    randEmpty = 1'b0;
    bit    randParity = 1'b0;

    int asserts = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [4:0] act, input logic [4:0] exp);
        asserts++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int act, input int exp);
        asserts++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        inFrame   = 1'b0;
        idleBauds = 0;
        expTrig   = 1'b0;
        expDone   = 1'b0;
        frame_q   = {};
    endtask

    task automatic model_baud();
        if (!inFrame) begin
            idleBauds++;
            if (idleBauds >= GAP && !p_FifoEmpty_i) begin
                frame_q = {};
                frame_q.push_back('{S_START, 4'd0});
                for (int i = 0; i < 8; i++) frame_q.push_back('{S_DATA, i[3:0]});
                if (p_ParityEn_i) frame_q.push_back('{S_PAR, 4'd0});
                for (int i = 0; i < STOPS; i++) frame_q.push_back('{S_STOP, 4'd0});
                latchedPar = p_ParityEn_i;
                inFrame    = 1'b1;
                startCycle = cycle;
            end
        end else begin
            if (frame_q[0].st == S_DATA && frame_q[0].bc == 4'd7) expTrig = 1'b1;
            void'(frame_q.pop_front());
            if (frame_q.size() == 0) begin
                inFrame   = 1'b0;
                idleBauds = 0;
                expDone   = 1'b1;
                if (fixed16)
                    chk_int("frame_clks", cycle - startCycle,
                            16 * (10 + int'(latchedPar) + STOPS - 1));
            end
        end
    endtask

    task automatic check_all();
        chk("state",  State_o, inFrame ? frame_q[0].st : S_INT);
        chk("bitcnt", {1'b0, BitCounter_o}, inFrame ? {1'b0, frame_q[0].bc} : 5'd0);
        chk("busy",   {4'd0, p_TxBusy_o}, {4'd0, inFrame});
        chk("trig",   {4'd0, p_ParityCalTrigger_o}, {4'd0, expTrig});
        chk("done",   {4'd0, p_FrameDone_o}, {4'd0, expDone});
    endtask

    task automatic tick(input logic b);
        @(negedge clk);
        p_BaudSig_i = b;
        if (randEmpty)  p_FifoEmpty_i = ($urandom_range(0, 3) == 0);
        if (randParity) p_ParityEn_i  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        expTrig = 1'b0;
        expDone = 1'b0;
        if (b && rst) model_baud();
        check_all();
    endtask

    task automatic period(input int n);
        tick(1'b1);
        repeat (n - 1) tick(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // FIFO empty: bauds pass, no frame starts
        p_FifoEmpty_i = 1'b1;
        repeat (5) period(3);
        // FIFO non-empty, parity off, baud every 16 clk
        fixed16 = 1'b1;
        p_FifoEmpty_i = 1'b0;
        p_ParityEn_i  = 1'b0;
        repeat (2 * (GAP + 10 + STOPS - 1) + 2) period(16);

        // Parity latched at start, input dropped during data bit 3
        p_ParityEn_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (inFrame && frame_q[0].st == S_DATA && frame_q[0].bc == 4'd3) p_ParityEn_i = 1'b0;
            period(16);
        end
        fixed16 = 1'b0;

        // Baud stalls for 1000 clk mid-frame
        for (int k = 0; k < 40 && !(inFrame && frame_q[0].st == S_DATA); k++) period(3);
        chk_int("reach_data", int'(inFrame), 1);
        repeat (1000) tick(1'b0);
        repeat (20) period(3);

        // Asynchronous reset while sitting on data bit 4
        for (int k = 0; k < 60 && !(inFrame && frame_q[0].st == S_DATA && frame_q[0].bc == 4'd4); k++)
            period(3);
        chk_int("reach_bit4", int'(inFrame), 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick(1'b1);
        tick(1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Random traffic
        randEmpty  = 1'b1;
        randParity = 1'b1;
        repeat (400) period($urandom_range(2, 5));
        randEmpty  = 1'b0;
        randParity = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Transmit frame sequencer for the UART TX path. It walks one-hot frame states (idle interval, start, 8 data bits, optional parity, stop) in step with the baud pulse. It drives the state and bit-index buses consumed by the TX shift register and parity generator. It starts a frame only when the send FIFO is non-empty, using the same condition that makes the shift register assert the FIFO read.

## Interface
- `IDLE_GAP`, default 1: number of baud pulses spent in INTERVAL before a start bit may begin (1..15).
- `clk` in 1: system clock, ≥40 MHz.
- `rst` in 1: asynchronous active-low reset; release synchronous to `clk`.
- `p_BaudSig_i` in 1: one-`clk`-wide pulse, once per bit period.
- `p_FifoEmpty_i` in 1: send FIFO empty flag (1 = empty).
- `p_ParityEn_i` in 1: 1 = insert a parity bit after the data bits.
- `State_o` out 5: one-hot state.
  - INTERVAL = 5'b0_0001
  - STARTBIT = 5'b0_0010
  - DATABITS = 5'b0_0100
  - PARITYBIT = 5'b0_1000
  - STOPBIT = 5'b1_0000
- `BitCounter_o` out 4: data bit index 0..7; valid in DATABITS, 0 otherwise.
- `p_ParityCalTrigger_o` out 1: 1-`clk` pulse on the DATABITS exit transition.
- `p_TxBusy_o` out 1: 1 in any state other than INTERVAL.
- `p_FrameDone_o` out 1: 1-`clk` pulse on the STOPBIT→INTERVAL transition.

## Operation
- All outputs are registered. Reset values:
  - `State_o` = INTERVAL
  - `BitCounter_o` = 0
  - gap counter = 0
  - all pulse outputs = 0
  - `p_TxBusy_o` = 0
- State advances only on `clk` edges where `p_BaudSig_i`=1. With no baud pulse, every register holds.
- INTERVAL:
  - Each baud pulse increments the gap counter, saturating at `IDLE_GAP`.
  - On a baud pulse with gap counter ≥ `IDLE_GAP`-1 and `p_FifoEmpty_i`=0: go to STARTBIT, clear the gap counter, and latch `p_ParityEn_i` into the internal `parity_en_r`.
  - With the FIFO empty, stay in INTERVAL (gap counter stays saturated).
- STARTBIT: on baud, go to DATABITS with `BitCounter_o`=0.
- DATABITS:
  - On baud with `BitCounter_o`<7: increment `BitCounter_o`.
  - On baud with `BitCounter_o`=7: clear `BitCounter_o`, pulse `p_ParityCalTrigger_o`, then go to PARITYBIT if `parity_en_r`=1, else to STOPBIT.
- PARITYBIT: on baud, go to STOPBIT.
- STOPBIT: on baud, go to INTERVAL (subject to Configuration), pulse `p_FrameDone_o`, gap counter = 0.
- `p_ParityEn_i` changes mid-frame are ignored; only the value latched at frame start applies.
- Illegal `State_o` encoding (not one-hot): next `clk` forces INTERVAL, `BitCounter_o`=0, gap counter=0, no pulses.
- `p_FifoEmpty_i` is sampled only in INTERVAL. A FIFO that goes empty mid-frame does not affect the current frame.
- Reset asserted mid-frame: immediate return to reset values. No done pulse is emitted.

## Timing
- Latency: a state change is visible one `clk` after the edge that samples `p_BaudSig_i`=1.
- Each non-INTERVAL state lasts exactly one baud period (two with the macro, STOPBIT only).
- Frame length in baud periods:
  - 10 with parity disabled
  - 11 with parity enabled
  - 12 with parity and the macro enabled
  - plus `IDLE_GAP` periods of INTERVAL between back-to-back frames
- The start condition is identical to the shift register's FIFO-read condition (INTERVAL & non-empty & baud). The FIFO read and the STARTBIT entry occur on the same edge.
- `p_ParityCalTrigger_o` and `p_FrameDone_o` are never high in the same cycle. Each is high for exactly one `clk`.

## Configuration
- `UART_TX_TWO_STOPBIT_EN` defined:
  - STOPBIT lasts two baud periods, using an internal 1-bit stop counter cleared on STOPBIT entry.
  - The first baud pulse in STOPBIT sets the stop counter and stays in STOPBIT.
  - The second baud pulse exits to INTERVAL.
- Macro undefined: one stop bit; the stop counter logic is absent.

## Test plan
- Reset mid-DATABITS (`BitCounter_o`=4), `rst`=0 → same cycle: `State_o`=5'b0_0001, `BitCounter_o`=0, `p_TxBusy_o`=0, no `p_FrameDone_o`.
- FIFO non-empty, parity off, baud every 16 clk, `IDLE_GAP`=1 → state sequence 00001→00010→00100(×8, counter 0..7)→10000→00001.
  - `p_ParityCalTrigger_o` fires once; `p_FrameDone_o` fires 160 clk after STARTBIT entry.
- Parity on at frame start, `p_ParityEn_i` deasserted during bit 3 → PARITYBIT still entered for one baud period; 11-period frame.
- FIFO empty for 5 baud pulses, then non-empty → stays in INTERVAL with `p_TxBusy_o`=0; STARTBIT is entered on the first baud pulse after `p_FifoEmpty_i`=0.
- Back-to-back frames with `IDLE_GAP`=3 → exactly 3 baud periods in INTERVAL between `p_FrameDone_o` and the next STARTBIT.
- `UART_TX_TWO_STOPBIT_EN` defined, parity off → STOPBIT held for 2 baud periods; frame = 11 periods.
- `p_BaudSig_i` held 0 for 1000 clk mid-frame → all outputs are frozen.
